// File: rtl/instr_fetch_queue.sv
// Instruction-fetch unit: owns the fetch PC, issues reads to a synchronous imem and
// buffers returned words with their PC in a prefetch FIFO drained by decode.
module instr_fetch_queue #(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         ADDR_W   = 10,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         imem_en,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [DATA_W-1:0]            imem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_instr,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   fetch_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];

  logic              pop;
  logic              fill;
  logic [CNT_W:0]    credit;

  // Issue gating counts the outstanding read as occupied so the queue never overflows.
  always_comb begin
    out_valid   = !reset && (count != '0);
    pop         = out_valid && out_ready;
    credit      = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    imem_en     = !reset && !redirect_valid && (credit < (CNT_W+1)'(DEPTH));
    imem_addr   = fetch_pc;
    fill        = inflight && !redirect_valid;
    out_instr   = out_valid ? q_instr[rd_ptr] : '0;
    out_pc      = out_valid ? q_pc[rd_ptr]    : '0;
    fetch_count = reset ? '0 : count;
  end

  // Control state; redirect flushes queue and drops the response arriving this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        req_pc   <= fetch_pc;
      end
      if (fill) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (fill && !pop)      count <= count + CNT_W'(1);
      else if (!fill && pop) count <= count - CNT_W'(1);
    end
  end

  // Queue storage: instruction word paired with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (!reset && fill) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized scoreboard bench for instr_fetch_queue: expected PC stream model plus
// timing/credit checks, with a second instance exercising PC wrap from 0x3FE.
module tb_instr_fetch_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC_A = 10'h000;
  localparam logic [ADDR_W-1:0] PC_B = 10'h3FE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, redirect_valid, out_ready;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_en, out_valid;
  logic [ADDR_W-1:0] imem_addr, out_pc;
  logic [DATA_W-1:0] imem_rdata, out_instr;
  logic [CNT_W-1:0]  fetch_count;

  logic              b_en, b_valid;
  logic [ADDR_W-1:0] b_addr, b_pc;
  logic [DATA_W-1:0] b_rdata, b_instr;
  logic [CNT_W-1:0]  b_count;

  instr_fetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(PC_A)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .fetch_count(fetch_count)
  );

  instr_fetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(PC_B)) dut_wrap (
    .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(10'h000),
    .imem_en(b_en), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .out_valid(b_valid), .out_ready(1'b1), .out_instr(b_instr), .out_pc(b_pc),
    .fetch_count(b_count)
  );

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return (DATA_W'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Synchronous imem: data valid only the cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    imem_rdata <= imem_en ? word_of(imem_addr) : $urandom;
    b_rdata    <= b_en    ? word_of(b_addr)    : $urandom;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] next_exp;

  // Drive one cycle of inputs; flush events restart the expected PC stream.
  task automatic cyc(input logic r, input logic rv, input logic [ADDR_W-1:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    reset = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = rdy;
    if (r) begin
      exp_q.delete();
      next_exp = PC_A;
    end else if (rv) begin
      exp_q.delete();
      next_exp = rpc;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + ADDR_W'(1);
    end
  endtask

  bit                mon_on = 1'b0;
  int                since = 0;
  int                pops = 0;
  int                pops_b = 0;
  logic              prev_en = 1'b0;
  logic [ADDR_W-1:0] exp_fetch;
  logic [ADDR_W-1:0] exp_b;

  // Monitor for the main instance: scoreboard pops plus fetch/credit/latency rules.
  always @(negedge clk) if (mon_on) begin
    if (reset) begin
      check("rst_imem_en", 32'(imem_en), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_instr", 32'(out_instr), 32'd0);
      check("rst_out_pc", 32'(out_pc), 32'd0);
      check("rst_fetch_count", 32'(fetch_count), 32'd0);
      since = 0;
      exp_fetch = PC_A;
    end else begin
      check("imem_addr", 32'(imem_addr), 32'(exp_fetch));
      check("count_bound", 32'(int'(fetch_count) <= int'(DEPTH)), 32'd1);
      check("valid_vs_count", 32'(out_valid), 32'(fetch_count != '0));
      if (!out_valid) check("idle_outputs_zero", 32'(out_pc) | out_instr, 32'd0);
      if (redirect_valid) begin
        check("redirect_no_issue", 32'(imem_en), 32'd0);
        since = 0;
        exp_fetch = redirect_pc;
      end else begin
        if (since < 1000) since++;
        check("valid_timing", 32'(out_valid), 32'(since >= 3));
        check("issue_rule", 32'(imem_en),
              32'((int'(fetch_count) + int'(prev_en) - int'(out_valid && out_ready)) < int'(DEPTH)));
        if (imem_en) exp_fetch = exp_fetch + ADDR_W'(1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_underrun: got pc 0x%0h expected none at %0t", out_pc, $time);
          end else begin
            logic [ADDR_W-1:0] p;
            p = exp_q.pop_front();
            check("out_pc", 32'(out_pc), 32'(p));
            check("out_instr", out_instr, word_of(p));
            pops++;
          end
        end
      end
    end
    prev_en = imem_en;
  end

  // Monitor for the wrap instance: always ready, stream starts at 0x3FE and wraps.
  always @(negedge clk) if (mon_on) begin
    if (reset) begin
      exp_b = PC_B;
    end else if (b_valid) begin
      check("wrap_pc", 32'(b_pc), 32'(exp_b));
      check("wrap_instr", b_instr, word_of(exp_b));
      exp_b = exp_b + ADDR_W'(1);
      pops_b++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    next_exp = PC_A;
    mon_on = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, '0, 1'b1);

    // Streaming from reset
    repeat (12) cyc(1'b0, 1'b0, '0, 1'b1);

    // Decode stall saturates the queue and stops issue
    repeat (10) cyc(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("stall_full", 32'(fetch_count), 32'(DEPTH));
    check("stall_no_issue", 32'(imem_en), 32'd0);
    repeat (10) cyc(1'b0, 1'b0, '0, 1'b1);

    // Redirect with queue filling and a read in flight
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 10'h200, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("redir_gap1", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("redir_gap2", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("redir_head_valid", 32'(out_valid), 32'd1);
    check("redir_head_pc", 32'(out_pc), 32'h200);
    repeat (8) cyc(1'b0, 1'b0, '0, 1'b1);

    // Reset mid-stream at occupancy 3
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      if (fetch_count == CNT_W'(3)) break;
    end
    check("reach_count3", 32'(fetch_count), 32'd3);
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("post_reset_valid", 32'(out_valid), 32'd0);
    check("post_reset_count", 32'(fetch_count), 32'd0);
    check("post_reset_addr", 32'(imem_addr), 32'(PC_A));
    repeat (6) cyc(1'b0, 1'b0, '0, 1'b1);

    // Redirect with simultaneous pop, then back-to-back redirects
    cyc(1'b0, 1'b1, 10'h010, 1'b1);
    @(negedge clk);
    check("redir_with_pop_valid", 32'(out_valid), 32'd1);
    cyc(1'b0, 1'b1, 10'h020, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("b2b_redir_pc", 32'(out_pc), 32'h020);
    repeat (6) cyc(1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 999);
      cyc(r < 5, (r >= 5) && (r < 60), ADDR_W'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (5) cyc(1'b0, 1'b0, '0, 1'b1);

    check("progress_main", 32'(pops > 1000), 32'd1);
    check("progress_wrap", 32'(pops_b > 1000), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
